uart_modem_status: RTL
======================

Name: uart_modem_status

Overview:
Modem-control/status stage of the APB UART. It consumes the asynchronous modem pad inputs (cts/dsr/ri/dcd) produced by the modem agent and drives the rts/dtr pad outputs back to it. It synchronises the inputs, maintains the 16550-style Modem Status Register (MSR) with delta/trailing-edge flags, handles loopback, and raises the modem-status interrupt. The register block reads MSR and supplies MCR and the IER modem-status enable bit.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per pad input (min 2)
FILTER_LEN, 4, glitch-filter stability count in PCLK cycles; used only with MODEM_GLITCH_FILTER_EN

Ports:
PCLK  input  1  system clock
PRESETn  input  1  asynchronous active-low reset
cts_pad_i  input  1  clear-to-send pad, active-low, asynchronous
dsr_pad_i  input  1  data-set-ready pad, active-low, asynchronous
ri_pad_i  input  1  ring-indicator pad, active-low, asynchronous
dcd_pad_i  input  1  carrier-detect pad, active-low, asynchronous
rts_pad_o  output  1  request-to-send pad, active-low
dtr_pad_o  output  1  data-terminal-ready pad, active-low
mcr  input  5  [0]=DTR [1]=RTS [2]=OUT1 [3]=OUT2 [4]=LOOP
ier_ms  input  1  modem-status interrupt enable
msr_rd  input  1  single-cycle strobe: MSR read this cycle
msr  output  8  [0]=DCTS [1]=DDSR [2]=TERI [3]=DDCD [4]=CTS [5]=DSR [6]=RI [7]=DCD
ms_int  output  1  modem-status interrupt, level

Behaviour:
- One clock (PCLK); reset asynchronous, active-low (PRESETn). All state clears on PRESETn low, regardless of clock.
- Reset values:
  - synchroniser flops = 1 (pads inactive)
  - msr = 8'h00, ms_int = 0
  - rts_pad_o = 1, dtr_pad_o = 1
  - previous-status register = 4'h0, so no delta is generated after reset release.
- Synchroniser: each pad passes through SYNC_STAGES flops. Status value = inverted synchronised pad (pad low -> bit 1).
- Loopback (mcr[4]=1):
  - status sources: CTS=mcr[1], DSR=mcr[0], RI=mcr[2], DCD=mcr[3], taken directly (no synchroniser).
  - pads ignored; rts_pad_o and dtr_pad_o forced to 1.
- Normal mode: rts_pad_o = ~mcr[1] and dtr_pad_o = ~mcr[0], both registered (1-cycle latency).
- Status update: msr[7:4] is registered from the selected sources. Latency from pad edge to msr[7:4]: SYNC_STAGES+1 PCLK edges normal; 1 edge in loopback.
- Delta flags are set in the same cycle msr[7:4] updates, comparing new vs previous:
  - DCTS/DDSR/DDCD on any change of CTS/DSR/DCD.
  - TERI only on RI 1->0 (pad low->high). RI 0->1 does not set TERI.
- Entering or leaving loopback is a normal source change; any resulting status change sets deltas.
- Delta clear: msr_rd=1 clears msr[3:0] on the next edge, except a bit whose set event occurs in that same cycle, which stays 1 (set wins, no event lost). msr[7:4] is never affected by msr_rd.
- Deltas are sticky: repeated changes before a read keep the bit at 1 with no count.
- ms_int is registered: ms_int <= ier_ms & |msr[3:0]. It asserts 1 cycle after a delta sets and deasserts 1 cycle after the clear or after ier_ms drops.
- Changes to ier_ms never alter msr.
- Reset mid-operation: all flags lost, returns to reset values immediately. The first status sample after release with pads active sets the corresponding delta.

Optional Feature:
MODEM_GLITCH_FILTER_EN
- Defined: each synchronised non-loopback input feeds a counter. The status bit updates only after the synchronised value differs from the current status for FILTER_LEN consecutive cycles; any reversion reloads the counter. Normal-mode latency becomes SYNC_STAGES+FILTER_LEN+1. Pulses shorter than FILTER_LEN cycles produce no status or delta change.
- Loopback path is unfiltered.
- Undefined: no counters; behaviour as in Behaviour.

Test Plan:
- Reset release, all pads 1, SYNC_STAGES=2 -> msr=8'h00, ms_int=0, rts_pad_o=dtr_pad_o=1, held for 20 cycles.
- cts_pad_i 1->0, ier_ms=1 -> msr=8'h11 three edges later; ms_int=1 one cycle after; msr_rd pulse -> msr=8'h10, ms_int=0 next cycle.
- ri_pad_i 1->0 -> msr=8'h40 (no TERI); then ri_pad_i 0->1 -> msr=8'h04, ms_int asserts.
- msr_rd on the same cycle DDSR sets -> msr[1]=1 retained; second msr_rd -> msr[1]=0.
- mcr=5'b1_1111 -> rts_pad_o=dtr_pad_o=1, msr[7:4]=4'hF one edge later with DCTS/DDSR/DDCD=1 and TERI=0; pad toggles during loop -> no msr change.
- With MODEM_GLITCH_FILTER_EN, FILTER_LEN=4: 3-cycle low pulse on dcd_pad_i -> msr unchanged; 6-cycle low -> msr=8'h88.

Source files
------------

// File: rtl/uart_modem_status_if.sv
// uart_modem_status_if: register-block side of the modem-control/status stage.
//   mcr    [0]=DTR [1]=RTS [2]=OUT1 [3]=OUT2 [4]=LOOP (from register block)
//   ier_ms modem-status interrupt enable (from register block)
//   msr_rd single-cycle MSR read strobe (from register block)
//   msr    [0]=DCTS [1]=DDSR [2]=TERI [3]=DDCD [4]=CTS [5]=DSR [6]=RI [7]=DCD
//   ms_int modem-status interrupt, level
// master = register block, slave = modem status stage.
interface uart_modem_status_if;
    logic [4:0] mcr;
    logic       ier_ms;
    logic       msr_rd;
    logic [7:0] msr;
    logic       ms_int;
    modport master (output mcr, ier_ms, msr_rd, input msr, ms_int);
    modport slave (input mcr, ier_ms, msr_rd, output msr, ms_int);
endinterface

// File: rtl/uart_modem_status.sv
// uart_modem_status: synchronises modem pads, keeps the 16550 MSR with delta flags,
// handles loopback and raises the modem-status interrupt.
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   cts/dsr/ri/dcd_pad_i     asynchronous active-low modem pad inputs
//   rts_pad_o, dtr_pad_o     active-low modem pad outputs (registered)
//   bus (slave modport)      mcr, ier_ms, msr_rd in; msr, ms_int out
// Optional MODEM_GLITCH_FILTER_EN: per-input stability filter of FILTER_LEN cycles
// on the synchronised (non-loopback) path.
module uart_modem_status #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic cts_pad_i,
    input  logic dsr_pad_i,
    input  logic ri_pad_i,
    input  logic dcd_pad_i,
    output logic rts_pad_o,
    output logic dtr_pad_o,
    uart_modem_status_if.slave bus
);
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
        $error("uart_modem_status: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    // Nibble order everywhere matches msr[7:4]: {DCD, RI, DSR, CTS}
    logic [3:0] pad, syn, norm, lb, src, chg, set;
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [7:0] msr_q;
    logic ms_int_q;

    assign pad = {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
    assign syn = ~sync_q[SYNC_STAGES-1];

    // Flops reset to 1 so the pads read as inactive until real samples arrive
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};

`ifdef MODEM_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [3:0] filt;
    logic [3:0][CW-1:0] cnt;
    // A bit follows the synchronised value only after FILTER_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            filt <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (syn[i] == filt[i])
                    cnt[i] <= '0;
                else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= syn[i];
                    cnt[i]  <= '0;
                end else
                    cnt[i] <= cnt[i] + 1'b1;
        end
    assign norm = filt;
`else
    assign norm = syn;
`endif

    assign lb  = {bus.mcr[3], bus.mcr[2], bus.mcr[0], bus.mcr[1]};
    assign src = bus.mcr[4] ? lb : norm;
    // msr_q[7:4] doubles as the previous-status register for edge detection
    assign chg = src ^ msr_q[7:4];
    assign set = {chg[3], msr_q[6] & ~src[2], chg[1:0]};

    // New set events are ORed after the read clear so a same-cycle event survives
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            msr_q     <= 8'h00;
            ms_int_q  <= 1'b0;
            rts_pad_o <= 1'b1;
            dtr_pad_o <= 1'b1;
        end else begin
            msr_q     <= {src, set | (bus.msr_rd ? 4'h0 : msr_q[3:0])};
            ms_int_q  <= bus.ier_ms & |msr_q[3:0];
            rts_pad_o <= bus.mcr[4] | ~bus.mcr[1];
            dtr_pad_o <= bus.mcr[4] | ~bus.mcr[0];
        end

    assign bus.msr    = msr_q;
    assign bus.ms_int = ms_int_q;
endmodule
